// File: rtl/risc_toy_fetch_queue.sv
// risc_toy_fetch_queue: credit-controlled instruction prefetcher feeding a
// DEPTH-entry queue that decode drains over a valid/ready handshake.
// REDIRECT flushes the queue and the in-flight fetch, then restarts fetch
// from the new target.
module risc_toy_fetch_queue #(
  parameter int              DEPTH    = 4,
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                         CLK,
  input  logic                         RSTN,
  output logic                         IREQ,
  output logic [PC_W-3:0]              IADDR,
  input  logic [31:0]                  INSTR,
  input  logic                         REDIRECT,
  input  logic [PC_W-1:0]              REDIRECT_PC,
  output logic                         DEC_VALID,
  input  logic                         DEC_READY,
  output logic [31:0]                  DEC_INSTR,
  output logic [PC_W-1:0]              DEC_PC,
  output logic [$clog2(DEPTH+1)-1:0]   COUNT
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W:0]  DEPTH_OCC = (CNT_W+1)'(DEPTH);
  // Clears the byte-offset bits of a redirect target.
  localparam logic [PC_W-1:0] WORD_MASK = ~(PC_W'(3));

  logic             started_q, started_d;
  logic [PC_W-1:0]  fpc_q, fpc_d;
  logic             inf_q, inf_d;
  logic [PC_W-1:0]  inf_pc_q, inf_pc_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [31:0]      instr_mem_q [DEPTH];
  logic [PC_W-1:0]  pc_mem_q    [DEPTH];

  logic [CNT_W:0]   occupancy;
  logic             issue;
  logic             push;
  logic             pop;
  logic             dec_valid;

  // Issue/push/pop decisions. Occupancy counts the in-flight fetch as a
  // reserved slot, and ignores a same-cycle pop, so the queue can never
  // overflow when the response lands.
  always_comb begin
    occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inf_q};
    dec_valid = (count_q != '0);
    issue     = started_q && !REDIRECT && (occupancy < DEPTH_OCC);
    push      = inf_q && !REDIRECT;
    pop       = dec_valid && DEC_READY && !REDIRECT;
  end

  // Next-state logic: REDIRECT overrides any push, pop or issue this cycle.
  always_comb begin
    started_d = 1'b1;
    fpc_d     = fpc_q;
    inf_d     = issue;
    inf_pc_d  = issue ? fpc_q : inf_pc_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (REDIRECT) begin
      fpc_d   = REDIRECT_PC & WORD_MASK;
      inf_d   = 1'b0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (issue) fpc_d = fpc_q + PC_W'(4);
      if (push)  tail_d = tail_q + PTR_W'(1);
      if (pop)   head_d = head_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      started_q <= 1'b0;
      fpc_q     <= RESET_PC;
      inf_q     <= 1'b0;
      inf_pc_q  <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
    end else begin
      started_q <= started_d;
      fpc_q     <= fpc_d;
      inf_q     <= inf_d;
      inf_pc_q  <= inf_pc_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  // Queue storage; contents are masked by COUNT so it needs no reset.
  always_ff @(posedge CLK) begin
    if (push) begin
      instr_mem_q[tail_q] <= INSTR;
      pc_mem_q[tail_q]    <= inf_pc_q;
    end
  end

  assign IREQ      = issue;
  assign IADDR     = fpc_q[PC_W-1:2];
  assign DEC_VALID = dec_valid;
  assign DEC_INSTR = dec_valid ? instr_mem_q[head_q] : 32'h0;
  assign DEC_PC    = dec_valid ? pc_mem_q[head_q] : '0;
  assign COUNT     = count_q;

endmodule

// File: tb/tb_risc_toy_fetch_queue.sv
// Directed testbench for risc_toy_fetch_queue. Instance u_dut uses the
// default 32-bit PC; instance u_wrap uses an 8-bit PC starting at 0xF8.
// Memory model: INSTR in cycle t equals {0, IADDR of cycle t-1}.
module tb_risc_toy_fetch_queue;

  logic        clk = 1'b0;
  logic        rstn;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        dec_ready;
  logic        ireq;
  logic [29:0] iaddr;
  logic [31:0] instr;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [2:0]  count;

  logic        rstn2;
  logic        redirect2 = 1'b0;
  logic [7:0]  redirect_pc2 = 8'h0;
  logic        dec_ready2;
  logic        ireq2;
  logic [5:0]  iaddr2;
  logic [31:0] instr2;
  logic        dec_valid2;
  logic [31:0] dec_instr2;
  logic [7:0]  dec_pc2;
  logic [2:0]  count2;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    instr  <= {2'b00, iaddr};
    instr2 <= {26'h0, iaddr2};
  end

  risc_toy_fetch_queue #(.DEPTH(4), .PC_W(32), .RESET_PC(32'h0)) u_dut (
    .CLK(clk), .RSTN(rstn), .IREQ(ireq), .IADDR(iaddr), .INSTR(instr),
    .REDIRECT(redirect), .REDIRECT_PC(redirect_pc), .DEC_VALID(dec_valid),
    .DEC_READY(dec_ready), .DEC_INSTR(dec_instr), .DEC_PC(dec_pc), .COUNT(count)
  );

  risc_toy_fetch_queue #(.DEPTH(4), .PC_W(8), .RESET_PC(8'hF8)) u_wrap (
    .CLK(clk), .RSTN(rstn2), .IREQ(ireq2), .IADDR(iaddr2), .INSTR(instr2),
    .REDIRECT(redirect2), .REDIRECT_PC(redirect_pc2), .DEC_VALID(dec_valid2),
    .DEC_READY(dec_ready2), .DEC_INSTR(dec_instr2), .DEC_PC(dec_pc2), .COUNT(count2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset u_dut and release it; the caller is then in cycle 0.
  task automatic start(input logic rdy);
    rstn = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; dec_ready = rdy;
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; dec_ready = 1'b0;
    tick(); tick();
    total++; if (ireq !== 1'b0) $display("FAIL reset_ireq got=%b exp=0", ireq); else passed++;
    total++; if (dec_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", dec_valid); else passed++;
    total++; if (count !== 3'd0) $display("FAIL reset_count got=%0d exp=0", count); else passed++;
    total++; if (dec_pc !== 32'h0) $display("FAIL reset_pc got=%h exp=0", dec_pc); else passed++;
    total++; if (dec_instr !== 32'h0) $display("FAIL reset_instr got=%h exp=0", dec_instr); else passed++;
    rstn = 1'b1;
    #1;
    total++; if (ireq !== 1'b0) $display("FAIL reset_c0_ireq got=%b exp=0", ireq); else passed++;
    tick();
    total++; if (ireq !== 1'b1) $display("FAIL reset_c1_ireq got=%b exp=1", ireq); else passed++;
    total++; if (iaddr !== 30'h0) $display("FAIL reset_c1_iaddr got=%h exp=0", iaddr); else passed++;
    $display("test_reset: done");
  endtask

  task automatic test_straight();
    start(1'b1);
    tick();
    total++; if (dec_valid !== 1'b0) $display("FAIL straight_c1_valid got=%b exp=0", dec_valid); else passed++;
    tick();
    total++; if (dec_valid !== 1'b0) $display("FAIL straight_c2_valid got=%b exp=0", dec_valid); else passed++;
    total++; if (iaddr !== 30'h1 || ireq !== 1'b1) $display("FAIL straight_c2_iaddr got=%h/%b exp=1/1", iaddr, ireq); else passed++;
    for (int k = 0; k < 8; k++) begin
      tick();
      total++;
      if (dec_valid !== 1'b1 || dec_pc !== 32'(4*k) || dec_instr !== 32'(k))
        $display("FAIL straight_pop%0d got v=%b pc=%h i=%h exp v=1 pc=%h i=%h",
                 k, dec_valid, dec_pc, dec_instr, 32'(4*k), 32'(k));
      else passed++;
    end
    $display("test_straight: done");
  endtask

  task automatic test_backpressure();
    start(1'b0);
    tick(); tick(); tick(); tick();
    total++; if (count !== 3'd2 || ireq !== 1'b1) $display("FAIL bp_c4 got cnt=%0d ireq=%b exp cnt=2 ireq=1", count, ireq); else passed++;
    tick();
    total++; if (count !== 3'd3 || ireq !== 1'b0) $display("FAIL bp_c5 got cnt=%0d ireq=%b exp cnt=3 ireq=0", count, ireq); else passed++;
    tick();
    total++; if (count !== 3'd4 || ireq !== 1'b0) $display("FAIL bp_c6 got cnt=%0d ireq=%b exp cnt=4 ireq=0", count, ireq); else passed++;
    total++; if (dec_valid !== 1'b1 || dec_pc !== 32'h0 || dec_instr !== 32'h0) $display("FAIL bp_c6_head got v=%b pc=%h i=%h exp 1/0/0", dec_valid, dec_pc, dec_instr); else passed++;
    tick();
    total++; if (count !== 3'd4 || dec_pc !== 32'h0 || dec_instr !== 32'h0) $display("FAIL bp_c7_hold got cnt=%0d pc=%h i=%h exp 4/0/0", count, dec_pc, dec_instr); else passed++;
    dec_ready = 1'b1;
    #1;
    total++; if (ireq !== 1'b0) $display("FAIL bp_c7_conservative got=%b exp=0", ireq); else passed++;
    for (int k = 1; k < 10; k++) begin
      tick();
      total++;
      if (dec_valid !== 1'b1 || dec_pc !== 32'(4*k) || dec_instr !== 32'(k))
        $display("FAIL bp_drain%0d got v=%b pc=%h i=%h exp v=1 pc=%h i=%h",
                 k, dec_valid, dec_pc, dec_instr, 32'(4*k), 32'(k));
      else passed++;
    end
    $display("test_backpressure: done");
  endtask

  task automatic test_redirect();
    start(1'b0);
    tick(); tick(); tick(); tick(); tick();
    total++; if (count !== 3'd3) $display("FAIL redir_pre_count got=%0d exp=3", count); else passed++;
    redirect = 1'b1; redirect_pc = 32'h103;
    #1;
    total++; if (ireq !== 1'b0) $display("FAIL redir_t_ireq got=%b exp=0", ireq); else passed++;
    tick();
    redirect = 1'b0;
    #1;
    total++; if (count !== 3'd0 || dec_valid !== 1'b0) $display("FAIL redir_t1_flush got cnt=%0d v=%b exp 0/0", count, dec_valid); else passed++;
    total++; if (ireq !== 1'b1 || iaddr !== 30'h40) $display("FAIL redir_t1_iaddr got=%b/%h exp 1/40", ireq, iaddr); else passed++;
    tick();
    total++; if (dec_valid !== 1'b0) $display("FAIL redir_t2_valid got=%b exp=0", dec_valid); else passed++;
    tick();
    total++; if (dec_valid !== 1'b1 || dec_pc !== 32'h100 || dec_instr !== 32'h40) $display("FAIL redir_t3_head got v=%b pc=%h i=%h exp 1/100/40", dec_valid, dec_pc, dec_instr); else passed++;
    dec_ready = 1'b1;
    tick();
    total++; if (dec_pc !== 32'h104 || dec_instr !== 32'h41) $display("FAIL redir_t4_head got pc=%h i=%h exp 104/41", dec_pc, dec_instr); else passed++;
    $display("test_redirect: done");
  endtask

  task automatic test_collide();
    start(1'b1);
    tick(); tick(); tick(); tick();
    total++; if (dec_valid !== 1'b1 || dec_pc !== 32'h4 || ireq !== 1'b1) $display("FAIL col_pre got v=%b pc=%h ireq=%b exp 1/4/1", dec_valid, dec_pc, ireq); else passed++;
    redirect = 1'b1; redirect_pc = 32'h200;
    #1;
    total++; if (ireq !== 1'b0) $display("FAIL col_t_ireq got=%b exp=0", ireq); else passed++;
    tick();
    redirect = 1'b0;
    #1;
    total++; if (count !== 3'd0 || dec_valid !== 1'b0) $display("FAIL col_t1_flush got cnt=%0d v=%b exp 0/0", count, dec_valid); else passed++;
    total++; if (ireq !== 1'b1 || iaddr !== 30'h80) $display("FAIL col_t1_iaddr got=%b/%h exp 1/80", ireq, iaddr); else passed++;
    tick();
    total++; if (dec_valid !== 1'b0) $display("FAIL col_t2_valid got=%b exp=0", dec_valid); else passed++;
    tick();
    total++; if (dec_pc !== 32'h200 || dec_instr !== 32'h80) $display("FAIL col_t3_head got pc=%h i=%h exp 200/80", dec_pc, dec_instr); else passed++;
    tick();
    total++; if (dec_pc !== 32'h204 || dec_instr !== 32'h81) $display("FAIL col_t4_head got pc=%h i=%h exp 204/81", dec_pc, dec_instr); else passed++;
    // Two redirects in consecutive cycles: the second target wins.
    redirect = 1'b1; redirect_pc = 32'h300;
    tick();
    redirect_pc = 32'h400;
    #1;
    total++; if (ireq !== 1'b0) $display("FAIL b2b_ireq got=%b exp=0", ireq); else passed++;
    tick();
    redirect = 1'b0;
    #1;
    total++; if (ireq !== 1'b1 || iaddr !== 30'h100) $display("FAIL b2b_iaddr got=%b/%h exp 1/100", ireq, iaddr); else passed++;
    tick(); tick();
    total++; if (dec_valid !== 1'b1 || dec_pc !== 32'h400 || dec_instr !== 32'h100) $display("FAIL b2b_head got v=%b pc=%h i=%h exp 1/400/100", dec_valid, dec_pc, dec_instr); else passed++;
    $display("test_collide: done");
  endtask

  task automatic test_reset_mid();
    start(1'b0);
    tick(); tick(); tick(); tick();
    total++; if (count !== 3'd2) $display("FAIL rmid_pre_count got=%0d exp=2", count); else passed++;
    #2;
    rstn = 1'b0;
    #1;
    total++; if (ireq !== 1'b0 || dec_valid !== 1'b0 || count !== 3'd0) $display("FAIL rmid_async got ireq=%b v=%b cnt=%0d exp 0/0/0", ireq, dec_valid, count); else passed++;
    tick();
    rstn = 1'b1;
    #1;
    total++; if (ireq !== 1'b0) $display("FAIL rmid_c0_ireq got=%b exp=0", ireq); else passed++;
    tick();
    total++; if (ireq !== 1'b1 || iaddr !== 30'h0) $display("FAIL rmid_c1 got ireq=%b iaddr=%h exp 1/0", ireq, iaddr); else passed++;
    tick(); tick();
    total++; if (dec_valid !== 1'b1 || dec_pc !== 32'h0) $display("FAIL rmid_c3 got v=%b pc=%h exp 1/0", dec_valid, dec_pc); else passed++;
    $display("test_reset_mid: done");
  endtask

  task automatic test_wrap();
    logic [7:0] exp_pc;
    logic [2:0] max_cnt;
    int pops;
    exp_pc = 8'hF8; max_cnt = 3'd0; pops = 0;
    dec_ready2 = 1'b0;
    rstn2 = 1'b1;
    for (int cyc = 0; cyc < 200 && pops < 16; cyc++) begin
      tick();
      dec_ready2 = ((cyc % 3) != 0);
      #1;
      if (count2 > max_cnt) max_cnt = count2;
      if (dec_valid2 && dec_ready2) begin
        total++;
        if (dec_pc2 !== exp_pc || dec_instr2 !== {26'h0, exp_pc[7:2]})
          $display("FAIL wrap_pop%0d got pc=%h i=%h exp pc=%h i=%h",
                   pops, dec_pc2, dec_instr2, exp_pc, {26'h0, exp_pc[7:2]});
        else passed++;
        exp_pc = exp_pc + 8'd4;
        pops++;
      end
    end
    total++; if (pops != 16) $display("FAIL wrap_timeout got pops=%0d exp=16", pops); else passed++;
    total++; if (max_cnt > 3'd4) $display("FAIL wrap_count_bound got max=%0d exp<=4", max_cnt); else passed++;
    $display("test_wrap: done, %0d pops", pops);
  endtask

  initial begin
    rstn = 1'b0; rstn2 = 1'b0; dec_ready2 = 1'b0;
    redirect = 1'b0; redirect_pc = 32'h0; dec_ready = 1'b0;
    #2;
    test_reset();
    test_straight();
    test_backpressure();
    test_redirect();
    test_collide();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/risc_toy_fetch_queue.md
Name: risc_toy_fetch_queue

Overview:
Parametrised instruction-fetch front end for the RISC_TOY core. It replaces the single-register PC/INSTR fetch with a credit-controlled prefetcher and a DEPTH-entry instruction queue, so fetch keeps running while decode is stalled. Decode pops instructions over a valid/ready handshake. Branch and jump resolution redirects fetch through REDIRECT, which flushes all queued and in-flight instructions.

Parameters:
DEPTH, 4, queue entries; power of two, >= 2.
PC_W, 32, PC width in bits; IADDR width is PC_W-2.
RESET_PC, 0, byte address fetched first after reset; low 2 bits must be 0.

Ports:
CLK  in  1  clock, rising edge.
RSTN  in  1  asynchronous, active-low reset.
IREQ  out  1  instruction memory request, valid this cycle.
IADDR  out  PC_W-2  word address for the request (byte PC >> 2).
INSTR  in  32  instruction data; valid exactly 1 cycle after an IREQ cycle.
REDIRECT  in  1  flush and restart fetch; single-cycle pulse from branch/jump logic.
REDIRECT_PC  in  PC_W  new fetch byte address; bits [1:0] ignored (treated as 0).
DEC_VALID  out  1  queue head is valid.
DEC_READY  in  1  decode accepts head.
DEC_INSTR  out  32  head instruction.
DEC_PC  out  PC_W  byte PC of the head instruction.
COUNT  out  $clog2(DEPTH+1)  current queue occupancy.

Behaviour:
- Reset (RSTN low, async): fetch PC fpc=RESET_PC; queue empty; in-flight flag inf=0; started=0. Outputs during reset: IREQ=0, DEC_VALID=0, DEC_INSTR=0, DEC_PC=0, COUNT=0.
- started sets to 1 on the first rising CLK edge after RSTN deasserts.
- Issue rule: IREQ = started && !REDIRECT && (COUNT + inf < DEPTH).
  - The check is conservative: a pop in the same cycle does not count.
  - IADDR = fpc[PC_W-1:2] whenever IREQ=1.
- On an IREQ cycle:
  - fpc <= fpc+4, wrapping modulo 2^PC_W.
  - inf <= 1, and inf_pc <= fpc.
  - Otherwise inf <= 0.
- Capture: when inf=1 and REDIRECT=0, INSTR and inf_pc are written to the tail entry at the clock edge.
- Pop: when DEC_VALID && DEC_READY, the head advances.
  - Simultaneous push and pop leaves COUNT unchanged.
  - Head and tail pointers wrap modulo DEPTH.
  - Overflow cannot occur by construction; bench asserts COUNT <= DEPTH.
- Output port: DEC_VALID = (COUNT != 0). DEC_INSTR and DEC_PC come from the head entry and are 0 when empty. They are stable while DEC_VALID && !DEC_READY.
- REDIRECT in cycle t:
  - IREQ=0 in cycle t.
  - The in-flight response arriving in cycle t is discarded.
  - At edge t: queue cleared, inf <= 0, fpc <= {REDIRECT_PC[PC_W-1:2],2'b00}.
  - Cycle t+1: DEC_VALID=0, IREQ=1, IADDR = target>>2.
  - Cycle t+3: DEC_VALID=1 with the target instruction.
  - REDIRECT wins over a simultaneous pop or push. A handshake in cycle t still counts as consumed by decode.
  - A response to an IREQ issued in cycle t-1 arrives in cycle t and is dropped.
  - Back-to-back REDIRECTs: the last one wins.
- Latency: first IREQ is at cycle 1 after reset release (started), with IADDR=RESET_PC>>2. Fetch to DEC_VALID is 2 cycles.
- Steady-state throughput is 1 instruction per cycle when DEC_READY is held 1.

Test Plan:
- Straight line: RESET_PC=0, DEC_READY=1, memory returns INSTR=IADDR.
  - Required: DEC_PC sequence 0,4,8,12… one per cycle, with DEC_INSTR = DEC_PC>>2.
  - First DEC_VALID 2 cycles after the first IREQ.
- Backpressure: DEC_READY=0 from start.
  - Required: COUNT rises to 4 and IREQ drops with COUNT+inf=4.
  - DEC_PC holds 0 and DEC_INSTR holds stable.
  - Raise DEC_READY: in-order drain 0,4,8,12,16…, with no gap after refill.
- Redirect flush: with queue holding 3 entries and inf=1, pulse REDIRECT with REDIRECT_PC=0x103.
  - Required: next cycle COUNT=0, DEC_VALID=0, IADDR=0x40.
  - Two cycles later DEC_PC=0x100. No stale instruction ever appears.
- Redirect + handshake collide: REDIRECT=1 in a cycle with DEC_VALID=DEC_READY=1 and a push pending.
  - Required: post-edge COUNT=0. The pending response is never emitted.
- Wrap: PC_W=8, RESET_PC=0xF8.
  - Required: DEC_PC 0xF8, 0xFC, 0x00, 0x04. Pointers wrap across ≥3 queue cycles with no loss.
- Reset mid-operation: assert RSTN low with COUNT=2 between edges.
  - Required: IREQ, DEC_VALID and COUNT go to 0 immediately (asynchronously).
  - After release: restart from RESET_PC, first IREQ 1 cycle later.
